// File: rtl/row_xor_read_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : row_xor_read_decoder_pkg
// Description : Shared definitions for the row XOR read decoder. Holds the
//               opcode encodings, the slot word field offsets
//               {valid, key, value} and the packed response record that
//               travels through the response FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package row_xor_read_decoder_pkg;

    // Geometry the response record is built for.
    localparam int PKG_NUM_MUL    = 4;
    localparam int PKG_NUM_WR     = 8;
    localparam int PKG_DATA_WIDTH = 64;
    localparam int PKG_KEY_WIDTH  = 32;
    localparam int PKG_SLOT_W     = $clog2(PKG_NUM_MUL);
    localparam int PKG_VAL_W      = PKG_DATA_WIDTH - 1 - PKG_KEY_WIDTH;

    // Slot word layout: valid at the MSB, key below it, value in the LSBs.
    localparam int VALID_BIT = PKG_DATA_WIDTH - 1;
    localparam int KEY_LSB   = PKG_VAL_W;
    localparam int VAL_WIDTH = PKG_VAL_W;

    localparam logic [1:0] OPT_IDLE   = 2'b00;
    localparam logic [1:0] OPT_SEARCH = 2'b01;
    localparam logic [1:0] OPT_INSERT = 2'b10;
    localparam logic [1:0] OPT_DELETE = 2'b11;

    typedef struct packed {
        logic [1:0]               opt;
        logic [PKG_KEY_WIDTH-1:0] key;
        logic                     hit;
        logic [PKG_SLOT_W-1:0]    hit_slot;
        logic [PKG_VAL_W-1:0]     value;
        logic                     free_vld;
        logic [PKG_SLOT_W-1:0]    free_slot;
        logic                     multi_hit;
    } resp_t;

endpackage
`default_nettype wire

// File: rtl/row_xor_read_decoder_fifo.sv
`default_nettype none
// ============================================================================
// Module      : resp_fifo_fwft
// Description : First-word-fall-through FIFO with wrap-bit pointers, a
//               registered almost-full flag and a sticky drop-on-full flag.
// Ports       : clk, reset (async active-low)
//               push, push_data      - write side, no backpressure
//               pop_ready            - consumer accepts head when head_valid
//               head_valid/head_data - combinational view of the head entry
//               almost_full          - free entries <= AF_MARGIN (registered)
//               overflow             - sticky, a push was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module resp_fifo_fwft #(
    parameter  int WIDTH     = 8,
    parameter  int DEPTH     = 8,
    parameter  int AF_MARGIN = 4,
    localparam int ADDR_W    = $clog2(DEPTH),
    localparam int PTR_W     = ADDR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic             almost_full,
    output logic             overflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] count;
    logic [PTR_W-1:0] next_count;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;
    logic             af_next;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

    // A pop frees the slot in the same cycle, so a push into a full FIFO
    // still lands when the head is leaving.
    assign do_pop  = !empty && pop_ready;
    assign do_push = push && (!full || do_pop);

    // Modular difference of wrap-bit pointers is the occupancy.
    assign count      = wr_ptr - rd_ptr;
    assign next_count = count + PTR_W'(do_push) - PTR_W'(do_pop);
    assign af_next    = (DEPTH - int'(next_count)) <= AF_MARGIN;

    assign head_valid = !empty;
    assign head_data  = mem[rd_ptr[ADDR_W-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[ADDR_W-1:0]] <= push_data;
                wr_ptr                  <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !do_push) begin
                overflow <= 1'b1;
            end
            almost_full <= af_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/row_xor_read_decoder.sv
`default_nettype none
// ============================================================================
// Module      : row_xor_read_decoder
// Description : Recovers each bucket slot by XOR-reducing the per-writer bank
//               words, matches the key, locates the first free slot and
//               queues one response per non-idle op into a FWFT FIFO.
// Ports       : clk, reset (async active-low)
//               rd_out_all/rd_key/rd_opt - free-running row pipeline output
//               resp_*                   - FIFO head fields, valid/ready
//               resp_almost_full         - upstream must stop issuing ops
//               overflow                 - sticky, a response was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module row_xor_read_decoder
    import row_xor_read_decoder_pkg::*;
#(
    parameter  int NUM_MUL    = PKG_NUM_MUL,
    parameter  int NUM_WR     = PKG_NUM_WR,
    parameter  int DATA_WIDTH = PKG_DATA_WIDTH,
    parameter  int KEY_WIDTH  = PKG_KEY_WIDTH,
    parameter  int FIFO_DEPTH = 8,
    parameter  int AF_MARGIN  = 4,
    localparam int SLOT_W     = $clog2(NUM_MUL),
    localparam int VAL_W      = DATA_WIDTH - 1 - KEY_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_MUL*NUM_WR*DATA_WIDTH-1:0] rd_out_all,
    input  logic [KEY_WIDTH-1:0]                 rd_key,
    input  logic [1:0]                           rd_opt,
    output logic                                 resp_valid,
    input  logic                                 resp_ready,
    output logic [1:0]                           resp_opt,
    output logic [KEY_WIDTH-1:0]                 resp_key,
    output logic                                 resp_hit,
    output logic [SLOT_W-1:0]                    resp_hit_slot,
    output logic [VAL_W-1:0]                     resp_value,
    output logic                                 resp_free_vld,
    output logic [SLOT_W-1:0]                    resp_free_slot,
    output logic                                 resp_multi_hit,
    output logic                                 resp_almost_full,
    output logic                                 overflow
);

    localparam int CNT_W = $clog2(NUM_MUL + 1);

    // ---------------- S1: XOR-reduce writers per slot ----------------
    logic [DATA_WIDTH-1:0] xor_word [NUM_MUL];
    logic [DATA_WIDTH-1:0] s1_word  [NUM_MUL];
    logic [KEY_WIDTH-1:0]  s1_key;
    logic [1:0]            s1_opt;

    always_comb begin
        for (int m = 0; m < NUM_MUL; m++) begin
            xor_word[m] = '0;
            for (int i = 0; i < NUM_WR; i++) begin
                xor_word[m] = xor_word[m] ^
                              rd_out_all[(i*NUM_MUL+m)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int m = 0; m < NUM_MUL; m++) begin
                s1_word[m] <= '0;
            end
            s1_key <= '0;
            s1_opt <= OPT_IDLE;
        end else begin
            for (int m = 0; m < NUM_MUL; m++) begin
                s1_word[m] <= xor_word[m];
            end
            s1_key <= rd_key;
            s1_opt <= rd_opt;
        end
    end

    // ---------------- S2: match, free search, value mux ----------------
    logic [NUM_MUL-1:0] hit_vec;
    logic [SLOT_W-1:0]  hit_slot_c;
    logic [SLOT_W-1:0]  free_slot_c;
    logic [VAL_W-1:0]   hit_value_c;
    logic [CNT_W-1:0]   hit_cnt;
    logic               free_any;
    resp_t              s2_next;
    resp_t              s2_resp;

    // Walking from the top slot down lets the lowest index win both
    // priority encoders without a separate "found" flag.
    always_comb begin
        hit_vec     = '0;
        hit_slot_c  = '0;
        free_slot_c = '0;
        hit_value_c = '0;
        hit_cnt     = '0;
        free_any    = 1'b0;
        for (int m = NUM_MUL - 1; m >= 0; m--) begin
            hit_vec[m] = s1_word[m][VALID_BIT] &&
                         (s1_word[m][KEY_LSB +: KEY_WIDTH] == s1_key);
            if (hit_vec[m]) begin
                hit_slot_c  = SLOT_W'(m);
                hit_value_c = s1_word[m][VAL_W-1:0];
            end
            if (!s1_word[m][VALID_BIT]) begin
                free_slot_c = SLOT_W'(m);
                free_any    = 1'b1;
            end
            hit_cnt = hit_cnt + CNT_W'(hit_vec[m]);
        end
    end

    always_comb begin
        s2_next           = '0;
        s2_next.opt       = s1_opt;
        s2_next.key       = s1_key;
        s2_next.hit       = |hit_vec;
        s2_next.hit_slot  = hit_slot_c;
        s2_next.value     = hit_value_c;
        s2_next.free_vld  = free_any;
        s2_next.free_slot = free_slot_c;
        s2_next.multi_hit = (hit_cnt > CNT_W'(1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_resp <= '0;
        end else begin
            s2_resp <= s2_next;
        end
    end

    // ---------------- S3: response FIFO ----------------
    resp_t head;
    logic  [$bits(resp_t)-1:0] head_bits;

    resp_fifo_fwft #(
        .WIDTH     ($bits(resp_t)),
        .DEPTH     (FIFO_DEPTH),
        .AF_MARGIN (AF_MARGIN)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (s2_resp.opt != OPT_IDLE),
        .push_data   (s2_resp),
        .pop_ready   (resp_ready),
        .head_valid  (resp_valid),
        .head_data   (head_bits),
        .almost_full (resp_almost_full),
        .overflow    (overflow)
    );

    assign head           = resp_t'(head_bits);
    assign resp_opt       = head.opt;
    assign resp_key       = head.key;
    assign resp_hit       = head.hit;
    assign resp_hit_slot  = head.hit_slot;
    assign resp_value     = head.value;
    assign resp_free_vld  = head.free_vld;
    assign resp_free_slot = head.free_slot;
    assign resp_multi_hit = head.multi_hit;

endmodule
`default_nettype wire

// File: doc/row_xor_read_decoder.md
Name: row_xor_read_decoder

Overview:
- Consumer end of the row read path: takes the raw per-writer, per-slot XOR-encoded bank words from the row read pipeline, together with the aligned key and opcode.
- XOR-reduces across writers to recover each bucket slot, matches the key, and locates a free slot.
- Queues one response per non-idle operation into an output FIFO with a valid/ready handshake toward the hash-table controller.
- Sits directly after the row pipeline output, before the control/update logic.

Parameters:
- NUM_MUL, 4: slots per bucket.
- NUM_WR, 8: write ports, i.e. XOR banks per slot.
- DATA_WIDTH, 64: slot word width. Format {valid[1], key[KEY_WIDTH], value[DATA_WIDTH-1-KEY_WIDTH]}, valid at the MSB.
- KEY_WIDTH, 32: key width.
- FIFO_DEPTH, 8: response FIFO entries; must be a power of 2 and ≥ 4.
- AF_MARGIN, 4: free-entry threshold for resp_almost_full.
- Local SLOT_W = clog2(NUM_MUL); VAL_W = DATA_WIDTH-1-KEY_WIDTH.

Ports:
- clk  in  1  clock
- reset  in  1  async active-low reset
- rd_out_all  in  NUM_MUL*NUM_WR*DATA_WIDTH  bank words; writer i, slot m at [(i*NUM_MUL+m)*DATA_WIDTH +: DATA_WIDTH]
- rd_key  in  KEY_WIDTH  key aligned with rd_out_all
- rd_opt  in  2  opcode: 00 idle, 01 search, 10 insert, 11 delete
- resp_valid  out  1  FIFO head valid
- resp_ready  in  1  consumer accepts head
- resp_opt  out  2  opcode of head
- resp_key  out  KEY_WIDTH  key of head
- resp_hit  out  1  key matched a valid slot
- resp_hit_slot  out  SLOT_W  lowest matching slot
- resp_value  out  VAL_W  value of matching slot (0 if no hit)
- resp_free_vld  out  1  at least one slot has valid=0
- resp_free_slot  out  SLOT_W  lowest invalid slot (0 if none)
- resp_multi_hit  out  1  more than one slot matched (table corruption)
- resp_almost_full  out  1  free FIFO entries ≤ AF_MARGIN
- overflow  out  1  sticky; a response was dropped

Behaviour:
- Input is free-running; there is no backpressure on rd_*. Every cycle with rd_opt≠00 produces exactly one response unless it is dropped.
- S1 (edge t+1): register, for each slot m, the XOR of the NUM_WR words for slot m; register rd_key and rd_opt.
- S2 (edge t+2): per slot, hit[m] = valid & (key==S1 key); free[m] = ~valid.
  - Priority encode lowest index for hit and for free.
  - multi_hit = popcount(hit) > 1.
  - Mux the value of the hit slot; value is 0 when there is no hit.
  - Register all of this with key and opt.
- S3 (edge t+3): push into the FIFO if S2 opt≠00.
- Output is first-word fall-through: resp_* are combinational from the FIFO head. With an empty FIFO, a response for input at cycle t is visible during cycle t+3.
- Pop occurs when resp_valid & resp_ready. resp_* fields are don't-care while resp_valid=0, but driven from storage, never X after reset.
- Full:
  - A push while full with no pop is dropped and sets overflow (sticky until reset). FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both succeed; count is unchanged.
- Empty: resp_ready is ignored; pointers hold.
- Pointers are log2(FIFO_DEPTH)+1 bits with wrap bit; full/empty derive from pointer compare. The count must stay consistent across pointer wrap.
- resp_almost_full is registered from the next-state count and asserts when (FIFO_DEPTH − count) ≤ AF_MARGIN. Upstream must stop issuing ops when it sees this; the margin covers S1–S3 in-flight entries.
- Reset (async assert, sync deassert by the environment) clears:
  - pipeline opt registers to 00;
  - FIFO pointers, so resp_valid=0;
  - overflow=0, resp_almost_full=0;
  - FIFO storage and S1/S2 data registers to 0.
- Reset mid-operation discards all in-flight and queued responses. There are no partial responses after deassert.
- Ops 10/11 carry identical decode; interpreting hit/free is the consumer's job.

Decomposition:
- Shared package holds:
  - opcode constants OPT_IDLE/OPT_SEARCH/OPT_INSERT/OPT_DELETE;
  - slot-field offset constants (valid bit index, key LSB, value width);
  - the response struct {opt, key, hit, hit_slot, value, free_vld, free_slot, multi_hit}.
- One sub-module: resp_fifo_fwft (parameterized width/depth, FWFT, count, full/empty, drop-on-full flag). The decoder instantiates it with the packed response struct.

Test Plan:
- Single search: writers 0–7 slot 2 words XOR to {1, key 0xDEADBEEF, value 0x1234}, rd_key=0xDEADBEEF, opt=01 at cycle 0, resp_ready=1 → cycle 3: resp_valid=1, hit=1, hit_slot=2, value=0x1234, multi_hit=0.
- Miss with free slot: slots 0,1 valid with other keys, slots 2,3 invalid, opt=10 → hit=0, value=0, free_vld=1, free_slot=2.
- Multi-hit: slots 1 and 3 both hold valid key 0x55 → hit_slot=1, multi_hit=1.
- Backpressure: resp_ready=0, issue 8 searches back-to-back → resp_almost_full rises once count reaches 4; issuing a 9th sets overflow=1. Draining then returns the 8 in order, and overflow stays 1.
- Full + simultaneous push/pop: FIFO full, resp_ready=1 while a new op arrives at S3 → no drop, count stays 8, overflow=0.
- Async reset: assert reset for 1 cycle with 3 ops in flight and 2 queued → resp_valid=0 immediately. No responses appear after deassert until a new op is issued, which appears 3 cycles later.
